// File: rtl/l2_wrr_req_arbiter_if.sv
// Request/bank bundle for the weighted round-robin L2 port arbiter.
// The requester side and the bank side share one interface; weights ride along as config.
interface l2_wrr_req_arbiter_if #(
  parameter int N_MASTER     = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH/8,
  parameter int ID_WIDTH     = N_MASTER,
  parameter int WEIGHT_WIDTH = 4,
  localparam int LOG_MASTER  = $clog2(N_MASTER)
);
  logic [N_MASTER-1:0]                   data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   data_add_i;
  logic [N_MASTER-1:0]                   data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]     data_be_i;
  logic [N_MASTER-1:0][ID_WIDTH-1:0]     data_ID_i;
  logic [N_MASTER-1:0]                   data_gnt_o;
  logic [N_MASTER-1:0][WEIGHT_WIDTH-1:0] weight_i;
  logic                                  data_req_o;
  logic [ADDR_WIDTH-1:0]                 data_add_o;
  logic                                  data_wen_o;
  logic [DATA_WIDTH-1:0]                 data_wdata_o;
  logic [BE_WIDTH-1:0]                   data_be_o;
  logic [ID_WIDTH-1:0]                   data_ID_o;
  logic                                  data_gnt_i;
  logic [LOG_MASTER-1:0]                 sel_o;

  // Arbiter view.
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  weight_i, data_gnt_i,
    output data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_ID_o, sel_o
  );

  // Requesters plus bank, as driven from outside the arbiter.
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output weight_i, data_gnt_i,
    input  data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_ID_o, sel_o
  );
endinterface

// File: rtl/l2_wrr_req_arbiter.sv
// Weighted round-robin arbiter for one L2 bank port: circular scan from the owner,
// owner keeps the port for up to weight_i[owner] accepted transfers.
module l2_wrr_gnt_lane #(
  parameter int LOG_MASTER = 2,
  parameter int IDX        = 0
) (
  input  logic [LOG_MASTER-1:0] sel,
  input  logic                  hs,
  output logic                  gnt
);
  assign gnt = hs & (sel == LOG_MASTER'(IDX));
endmodule

module l2_wrr_req_arbiter #(
  parameter int N_MASTER     = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH/8,
  parameter int ID_WIDTH     = N_MASTER,
  parameter int WEIGHT_WIDTH = 4,
  localparam int LOG_MASTER  = $clog2(N_MASTER)
) (
  input  logic clk,
  input  logic rst_n,
  l2_wrr_req_arbiter_if.slave bus
);
  logic [LOG_MASTER-1:0]   ptr_q, sel, ptr_n;
  logic [WEIGHT_WIDTH-1:0] cnt_q, wsel;
  logic [WEIGHT_WIDTH:0]   cnt_n, w;
  logic                    hs;

  // First requester scanning circularly from the owner; owner index when idle.
  always_comb begin
    int  idx;
    logic found;
    sel   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (!found && bus.data_req_i[idx]) begin
        sel   = idx[LOG_MASTER-1:0];
        found = 1'b1;
      end
    end
  end

  assign bus.data_req_o   = |bus.data_req_i;
  assign bus.data_add_o   = bus.data_add_i[sel];
  assign bus.data_wen_o   = bus.data_wen_i[sel];
  assign bus.data_wdata_o = bus.data_wdata_i[sel];
  assign bus.data_be_o    = bus.data_be_i[sel];
  assign bus.data_ID_o    = bus.data_ID_i[sel];
  assign bus.sel_o        = sel;

  assign hs = bus.data_req_o & bus.data_gnt_i;

  for (genvar g = 0; g < N_MASTER; g++) begin : g_lane
    l2_wrr_gnt_lane #(.LOG_MASTER(LOG_MASTER), .IDX(g)) u_lane (
      .sel (sel),
      .hs  (hs),
      .gnt (bus.data_gnt_o[g])
    );
  end

  // One extra bit so cnt_q+1 never wraps against the weight compare.
  assign wsel  = bus.weight_i[sel];
  assign w     = (wsel == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, wsel};
  assign cnt_n = (sel == ptr_q) ? ({1'b0, cnt_q} + 1'b1) : (WEIGHT_WIDTH+1)'(1);
  assign ptr_n = (sel == LOG_MASTER'(N_MASTER-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (hs) begin
      if (cnt_n >= w) begin
        ptr_q <= ptr_n;
        cnt_q <= '0;
      end else begin
        ptr_q <= sel;
        cnt_q <= cnt_n[WEIGHT_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_l2_wrr_req_arbiter.sv
// Directed bench: stimulus queues the expected winner per cycle, a negedge monitor
// checks every bank handshake against the queue.
module tb_l2_wrr_req_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  l2_wrr_req_arbiter_if #(.N_MASTER(N)) ifc ();

  l2_wrr_req_arbiter #(.N_MASTER(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest queued winner.
  always @(negedge clk) begin
    if (rst_n && ifc.data_req_o && ifc.data_gnt_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: sel %0d, nothing queued", ifc.sel_o);
      end else begin
        int m;
        m = exp_q.pop_front();
        chk("hs_sel",  int'(ifc.sel_o), m);
        chk("hs_gnt",  int'(ifc.data_gnt_o), 1 << m);
        chk("hs_add",  int'(ifc.data_add_o), 'h100 + m);
        chk("hs_data", int'(ifc.data_wdata_o), 'hA0 + m);
        chk("hs_id",   int'(ifc.data_ID_o), 1 << m);
      end
    end
  end

  // Set inputs just after posedge, queue expected winner (-1: no handshake), run one cycle.
  task automatic step(input logic [N-1:0] req, input logic gnt, input int exp);
    ifc.data_req_i = req;
    ifc.data_gnt_i = gnt;
    if (exp >= 0) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    ifc.weight_i[0] = 4'(w0);
    ifc.weight_i[1] = 4'(w1);
    ifc.weight_i[2] = 4'(w2);
    ifc.weight_i[3] = 4'(w3);
  endtask

  task automatic do_reset();
    ifc.data_req_i = '0;
    ifc.data_gnt_i = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int cnt_seq[10];
    for (int m = 0; m < N; m++) begin
      ifc.data_add_i[m]   = 12'(12'h100 + m);
      ifc.data_wdata_i[m] = 32'(32'hA0 + m);
      ifc.data_ID_i[m]    = 4'(1 << m);
      ifc.data_be_i[m]    = 4'(m);
      ifc.data_wen_i[m]   = m[0];
    end
    set_w(1, 1, 1, 1);

    // Reset held with everything requesting and the bank granting.
    ifc.data_req_i = 4'b1111;
    ifc.data_gnt_i = 1'b1;
    #2;
    chk("rst_sel", int'(ifc.sel_o), 0);
    chk("rst_gnt", int'(ifc.data_gnt_o), 1);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ptr", int'(dut.ptr_q), 0);
    chk("rst_cnt", int'(dut.cnt_q), 0);
    ifc.data_req_i = '0;
    #1;
    chk("rst_idle_req", int'(ifc.data_req_o), 0);
    chk("rst_idle_add", int'(ifc.data_add_o), 'h100);
    rst_n = 1'b1;

    // Equal weights: plain round robin with 3->0 wrap.
    foreach (cnt_seq[i]) cnt_seq[i] = 0;
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b1, 1);
    step(4'b1111, 1'b1, 2);
    step(4'b1111, 1'b1, 3);
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b1, 1);
    chk("rr_ptr", int'(dut.ptr_q), 2);

    // Weights {3,1,2,1}.
    do_reset();
    set_w(3, 1, 2, 1);
    cnt_seq = '{1, 2, 0, 0, 1, 0, 0, 1, 2, 0};
    begin
      int seq[10];
      seq = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
      for (int i = 0; i < 10; i++) begin
        step(4'b1111, 1'b1, seq[i]);
        chk($sformatf("wrr_cnt%0d", i), int'(dut.cnt_q), cnt_seq[i]);
      end
    end

    // Backpressure mid-turn.
    do_reset();
    set_w(2, 1, 1, 1);
    step(4'b1111, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      ifc.data_req_i = 4'b1111;
      ifc.data_gnt_i = 1'b0;
      #1;
      chk("bp_sel", int'(ifc.sel_o), 0);
      chk("bp_gnt", int'(ifc.data_gnt_o), 0);
      step(4'b1111, 1'b0, -1);
      chk("bp_cnt", int'(dut.cnt_q), 1);
    end
    step(4'b1111, 1'b1, 0);
    chk("bp_ptr", int'(dut.ptr_q), 1);
    chk("bp_cnt_end", int'(dut.cnt_q), 0);

    // Owner drops mid-turn, loses its budget.
    do_reset();
    set_w(4, 1, 1, 1);
    step(4'b0001, 1'b1, 0);
    step(4'b0001, 1'b1, 0);
    chk("drop_cnt2", int'(dut.cnt_q), 2);
    step(4'b0100, 1'b1, 2);
    chk("drop_ptr", int'(dut.ptr_q), 3);
    step(4'b0001, 1'b1, 0);
    chk("drop_ptr0", int'(dut.ptr_q), 0);
    chk("drop_cnt1", int'(dut.cnt_q), 1);

    // Zero weights behave as one; sparse requesters alternate.
    do_reset();
    set_w(0, 0, 0, 0);
    step(4'b1010, 1'b1, 1);
    step(4'b1010, 1'b1, 3);
    step(4'b1010, 1'b1, 1);
    ifc.data_req_i = '0;
    ifc.data_gnt_i = 1'b1;
    #1;
    chk("idle_req", int'(ifc.data_req_o), 0);
    chk("idle_sel", int'(ifc.sel_o), 2);
    chk("idle_gnt", int'(ifc.data_gnt_o), 0);
    step(4'b0000, 1'b1, -1);
    chk("idle_ptr", int'(dut.ptr_q), 2);
    chk("idle_cnt", int'(dut.cnt_q), 0);

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, 0 expected");
    $fatal(1);
  end
endmodule
